ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader_pkg.sv | 14 +
 rtl/ram_loader.sv | 115 +++++++++++
 tb/tb_ram_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the program RAM loader: loader FSM states and RAM depth.
package ram_loader_pkg;

  // Number of words in the program RAM; the loader never addresses beyond it.
  localparam int RAM_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/ram_loader.sv
// Program RAM loader: accepts bytes from the host one at a time, writes them to
// consecutive RAM addresses starting at 0, keeps a running mod-2^DATA_W checksum
// and holds the CPU while a load is in progress.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = $clog2(RAM_WORDS),
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int              DEPTH_I = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH   = DEPTH_I[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] cnt;
  logic            last;

  // A length of zero means a full RAM; anything larger than the RAM is clipped.
  function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] n);
    if (n == '0 || n > DEPTH) return DEPTH;
    else                      return n;
  endfunction

  // The word being written is the last one when the next count reaches the length.
  // The counter is not advanced past the last word, so it never leaves the RAM range.
  assign last     = (cnt + ONE) == len;
  assign ram_addr = cnt[ADDR_W-1:0];

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      len      <= '0;
      cnt      <= '0;
      in_ready <= 1'b0;
      ram_we   <= 1'b0;
      ram_data <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE: begin
          // abort has no effect here, so a coincident start always wins
          if (start) begin
            len      <= sat_len(load_len);
            cnt      <= '0;
            checksum <= '0;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            state    <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (abort) begin
            in_ready <= 1'b0;
            cpu_hold <= 1'b0;
            state    <= IDLE;
          end else if (in_valid && in_ready) begin
            ram_data <= in_data;
            ram_we   <= 1'b1;
            in_ready <= 1'b0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          // the strobe raised on the handshake completes here even when aborting
          ram_we   <= 1'b0;
          checksum <= checksum + ram_data;
          if (!last) cnt <= cnt + ONE;
          if (abort) begin
            cpu_hold <= 1'b0;
            state    <= IDLE;
          end else if (last) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            in_ready <= 1'b1;
            state    <= ACCEPT;
          end
        end
        FINISH: begin
          done     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          ram_we   <= 1'b0;
          cpu_hold <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: directed scenarios plus randomized loads
// compared against a simple list-of-writes / sum reference model.
module tb_ram_loader;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic          cpu_hold;
  logic          done;
  logic [DW-1:0] checksum;

  ram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .cpu_hold(cpu_hold), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  logic [DW-1:0] pbytes [16];
  logic [DW-1:0] ram_model [16];
  logic [AW-1:0] mon_addr [$];
  logic [DW-1:0] mon_data [$];
  int            mon_cyc [$];
  int            cyc = 0;
  int            done_cnt = 0;
  int            hold_drop = 0;
  int            b2b_cnt = 0;
  bit            in_load = 1'b0;
  logic          prev_we = 1'b0;

  // Passive observer: records every RAM write, done pulses and cpu_hold drops.
  always @(negedge clk) begin
    cyc++;
    if (ram_we === 1'b1) begin
      mon_addr.push_back(ram_addr);
      mon_data.push_back(ram_data);
      mon_cyc.push_back(cyc);
      ram_model[ram_addr] = ram_data;
    end
    if (ram_we === 1'b1 && prev_we === 1'b1) b2b_cnt++;
    prev_we = ram_we;
    if (done === 1'b1) done_cnt++;
    if (in_load && cpu_hold !== 1'b1) hold_drop++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int eff_len(input int len);
    return (len == 0 || len > 16) ? 16 : len;
  endfunction

  function automatic logic [DW-1:0] ref_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(pbytes[i]);
    return DW'(s % 256);
  endfunction

  // Host-side driver: start a load and offer bytes from pbytes[] until the load
  // completes or the requested abort point is reached.
  task automatic run_load(input int len, input int stall, input int abort_after,
                          input int glitch_at, input bit keep_valid,
                          input bit abort_at_start, output int sent);
    int eff, n;
    bit hs;
    eff = eff_len(len);
    sent = 0;
    mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
    done_cnt = 0; hold_drop = 0; b2b_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; load_len = len[AW:0]; abort = abort_at_start;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; load_len = 5'($urandom_range(0, 31));
    in_load = 1'b1;
    for (int i = 0; i < eff; i++) begin
      n = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      if (n > 0 || !keep_valid) in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
      if (glitch_at == i) begin
        start = 1'b1; load_len = 5'd7;
        @(posedge clk); #1;
        start = 1'b0;
      end
      in_valid = 1'b1; in_data = pbytes[i];
      hs = 1'b0;
      for (int t = 0; t < 40 && !hs; t++) begin
        @(negedge clk); hs = (in_ready === 1'b1);
        @(posedge clk); #1;
      end
      nchk++;
      if (!hs) begin
        nfail++;
        $display("FAIL handshake_timeout byte=%0d in_ready=0 required=1", i);
        in_valid = 1'b0; in_load = 1'b0;
        return;
      end
      sent++;
      if (!keep_valid) in_valid = 1'b0;
      if (sent == abort_after) begin
        in_valid = 1'b0; abort = 1'b1; in_load = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    in_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; in_valid = 1'b1; load_len = 5'd3; in_data = 8'h77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchk++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    nchk++; if (ram_we !== 1'b0) begin nfail++; $display("FAIL reset_ram_we got=%b want=0", ram_we); end
    nchk++; if (ram_addr !== '0) begin nfail++; $display("FAIL reset_ram_addr got=%h want=0", ram_addr); end
    nchk++; if (ram_data !== '0) begin nfail++; $display("FAIL reset_ram_data got=%h want=0", ram_data); end
    nchk++; if (cpu_hold !== 1'b0) begin nfail++; $display("FAIL reset_cpu_hold got=%b want=0", cpu_hold); end
    nchk++; if (done !== 1'b0) begin nfail++; $display("FAIL reset_done got=%b want=0", done); end
    nchk++; if (checksum !== '0) begin nfail++; $display("FAIL reset_checksum got=%h want=0", checksum); end
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_basic();
    int sent;
    pbytes[0] = 8'h0E; pbytes[1] = 8'h1F; pbytes[2] = 8'h2F;
    run_load(3, 0, 0, -1, 1'b1, 1'b0, sent);
    nchk++; if (mon_addr.size() != 3) begin nfail++; $display("FAIL basic_write_count got=%0d want=3", mon_addr.size()); end
    for (int i = 0; i < mon_addr.size() && i < 3; i++) begin
      nchk++;
      if (mon_addr[i] !== AW'(i) || mon_data[i] !== pbytes[i]) begin
        nfail++; $display("FAIL basic_write%0d got=%h:%h want=%h:%h", i, mon_addr[i], mon_data[i], AW'(i), pbytes[i]);
      end
    end
    for (int i = 1; i < mon_cyc.size(); i++) begin
      nchk++;
      if (mon_cyc[i] - mon_cyc[i-1] != 2) begin nfail++; $display("FAIL basic_write_spacing got=%0d want=2", mon_cyc[i] - mon_cyc[i-1]); end
    end
    nchk++; if (done_cnt != 1) begin nfail++; $display("FAIL basic_done_count got=%0d want=1", done_cnt); end
    nchk++; if (checksum !== 8'h5C) begin nfail++; $display("FAIL basic_checksum got=%h want=5c", checksum); end
    nchk++; if (hold_drop != 0) begin nfail++; $display("FAIL basic_cpu_hold_drops got=%0d want=0", hold_drop); end
    nchk++; if (cpu_hold !== 1'b0 || in_ready !== 1'b0) begin nfail++; $display("FAIL basic_idle_after hold=%b ready=%b want=0 0", cpu_hold, in_ready); end
  endtask

  task automatic test_full();
    int sent;
    for (int i = 0; i < 16; i++) pbytes[i] = 8'h01;
    run_load(0, 0, 0, -1, 1'b1, 1'b0, sent);
    repeat (5) begin @(posedge clk); #1; end
    nchk++; if (mon_addr.size() != 16) begin nfail++; $display("FAIL full_write_count got=%0d want=16", mon_addr.size()); end
    for (int i = 0; i < mon_addr.size() && i < 16; i++) begin
      nchk++;
      if (mon_addr[i] !== AW'(i) || mon_data[i] !== 8'h01) begin
        nfail++; $display("FAIL full_write%0d got=%h:%h want=%h:01", i, mon_addr[i], mon_data[i], AW'(i));
      end
    end
    nchk++; if (checksum !== 8'h10) begin nfail++; $display("FAIL full_checksum got=%h want=10", checksum); end
    nchk++; if (done_cnt != 1) begin nfail++; $display("FAIL full_done_count got=%0d want=1", done_cnt); end
    nchk++; if (ram_addr !== 4'hF) begin nfail++; $display("FAIL full_addr_no_wrap got=%h want=f", ram_addr); end
  endtask

  task automatic test_stall();
    int sent;
    for (int i = 0; i < 4; i++) pbytes[i] = 8'($urandom);
    run_load(4, 5, 0, -1, 1'b0, 1'b0, sent);
    nchk++; if (mon_addr.size() != 4) begin nfail++; $display("FAIL stall_write_count got=%0d want=4", mon_addr.size()); end
    for (int i = 0; i < mon_addr.size() && i < 4; i++) begin
      nchk++;
      if (mon_addr[i] !== AW'(i) || mon_data[i] !== pbytes[i]) begin
        nfail++; $display("FAIL stall_write%0d got=%h:%h want=%h:%h", i, mon_addr[i], mon_data[i], AW'(i), pbytes[i]);
      end
    end
    for (int i = 1; i < mon_cyc.size(); i++) begin
      nchk++;
      if (mon_cyc[i] - mon_cyc[i-1] != 6) begin nfail++; $display("FAIL stall_write_spacing got=%0d want=6", mon_cyc[i] - mon_cyc[i-1]); end
    end
    nchk++; if (checksum !== ref_sum(4)) begin nfail++; $display("FAIL stall_checksum got=%h want=%h", checksum, ref_sum(4)); end
    nchk++; if (done_cnt != 1) begin nfail++; $display("FAIL stall_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_abort();
    int sent;
    for (int i = 0; i < 4; i++) pbytes[i] = 8'($urandom);
    run_load(4, 0, 2, -1, 1'b1, 1'b0, sent);
    nchk++; if (cpu_hold !== 1'b0 || in_ready !== 1'b0) begin nfail++; $display("FAIL abort_idle_next hold=%b ready=%b want=0 0", cpu_hold, in_ready); end
    repeat (4) begin @(posedge clk); #1; end
    nchk++; if (mon_addr.size() != 2) begin nfail++; $display("FAIL abort_write_count got=%0d want=2", mon_addr.size()); end
    nchk++; if (done_cnt != 0) begin nfail++; $display("FAIL abort_done_count got=%0d want=0", done_cnt); end
    nchk++; if (checksum !== ref_sum(2)) begin nfail++; $display("FAIL abort_checksum got=%h want=%h", checksum, ref_sum(2)); end
  endtask

  task automatic test_reset_midload();
    int sent;
    mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
    @(posedge clk); #1;
    start = 1'b1; load_len = 5'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    nchk++;
    if ({in_ready, ram_we, ram_addr, ram_data, cpu_hold, done, checksum} !== '0) begin
      nfail++; $display("FAIL midreset_outputs got=%b%b_%h_%h_%b%b_%h want=all zero", in_ready, ram_we, ram_addr, ram_data, cpu_hold, done, checksum);
    end
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    nchk++; if (mon_addr.size() != 2) begin nfail++; $display("FAIL midreset_write_count got=%0d want=2", mon_addr.size()); end
    pbytes[0] = 8'hAA;
    run_load(1, 0, 0, -1, 1'b0, 1'b0, sent);
    nchk++; if (mon_addr.size() != 1 || mon_addr[0] !== 4'h0 || mon_data[0] !== 8'hAA) begin
      nfail++; $display("FAIL midreset_reload_write count=%0d want=1 at 0 with aa", mon_addr.size());
    end
    nchk++; if (checksum !== 8'hAA) begin nfail++; $display("FAIL midreset_checksum got=%h want=aa", checksum); end
    nchk++; if (ram_model[1] !== 8'h55 || ram_model[0] !== 8'hAA) begin
      nfail++; $display("FAIL midreset_ram_contents got=%h,%h want=aa,55", ram_model[0], ram_model[1]);
    end
  endtask

  task automatic test_start_ignored();
    int sent;
    for (int i = 0; i < 3; i++) pbytes[i] = 8'($urandom);
    run_load(3, 2, 0, 1, 1'b0, 1'b0, sent);
    nchk++; if (mon_addr.size() != 3) begin nfail++; $display("FAIL glitch_write_count got=%0d want=3", mon_addr.size()); end
    for (int i = 0; i < mon_addr.size() && i < 3; i++) begin
      nchk++;
      if (mon_addr[i] !== AW'(i) || mon_data[i] !== pbytes[i]) begin
        nfail++; $display("FAIL glitch_write%0d got=%h:%h want=%h:%h", i, mon_addr[i], mon_data[i], AW'(i), pbytes[i]);
      end
    end
    nchk++; if (done_cnt != 1) begin nfail++; $display("FAIL glitch_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_random();
    int len, eff, ab, nexp, sent;
    for (int k = 0; k < 20; k++) begin
      len = $urandom_range(0, 20);
      eff = eff_len(len);
      for (int i = 0; i < 16; i++) pbytes[i] = 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, eff)) : 0;
      run_load(len, -1, ab, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sent);
      nexp = (ab != 0) ? ab : eff;
      repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
      nchk++; if (mon_addr.size() != nexp) begin nfail++; $display("FAIL rand%0d_write_count got=%0d want=%0d", k, mon_addr.size(), nexp); end
      for (int i = 0; i < mon_addr.size() && i < nexp; i++) begin
        nchk++;
        if (mon_addr[i] !== AW'(i) || mon_data[i] !== pbytes[i]) begin
          nfail++; $display("FAIL rand%0d_write%0d got=%h:%h want=%h:%h", k, i, mon_addr[i], mon_data[i], AW'(i), pbytes[i]);
        end
      end
      nchk++; if (checksum !== ref_sum(nexp)) begin nfail++; $display("FAIL rand%0d_checksum got=%h want=%h", k, checksum, ref_sum(nexp)); end
      nchk++; if (done_cnt != ((ab != 0) ? 0 : 1)) begin nfail++; $display("FAIL rand%0d_done_count got=%0d want=%0d", k, done_cnt, (ab != 0) ? 0 : 1); end
      nchk++; if (hold_drop != 0 || b2b_cnt != 0) begin nfail++; $display("FAIL rand%0d_hold_or_rate hold_drops=%0d b2b=%0d want=0 0", k, hold_drop, b2b_cnt); end
      nchk++; if (cpu_hold !== 1'b0) begin nfail++; $display("FAIL rand%0d_idle_hold got=%b want=0", k, cpu_hold); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_stall();
    test_abort();
    test_reset_midload();
    test_start_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
